// File: rtl/cb_pkg.sv
// Shared defaults and helpers for the N x M round-robin crossbar.
// Imported by the arbiter and the crossbar top.
package cb_pkg;

    localparam int CB_WIDTH = 8;
    localparam int CB_N_SRC = 4;
    localparam int CB_N_DST = 4;

    // Ceiling log2 for n >= 2; used to size index fields.
    function automatic int cb_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cb_rr_arb.sv
// Round-robin arbiter for one crossbar destination.
// The pointer moves past the winner only when the grant is taken.
module cb_rr_arb
    import cb_pkg::*;
#(
    parameter int N_SRC = CB_N_SRC,
    localparam int SW = cb_clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    input  logic             advance,
    output logic [N_SRC-1:0] gnt,
    output logic [SW-1:0]    gnt_idx
);

    logic [SW-1:0] ptr;
    logic [SW:0]   pos;
    logic          found;

    // First requester at or after ptr, wrapping modulo N_SRC.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < N_SRC; k++) begin
            pos = {1'b0, ptr} + (SW+1)'(k);
            if (pos >= (SW+1)'(N_SRC)) begin
                pos = pos - (SW+1)'(N_SRC);
            end
            if (!found && req[pos[SW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = pos[SW-1:0];
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            if (gnt_idx == SW'(N_SRC - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cb_rr_nxm.sv
// N-source x M-destination crossbar with per-destination round-robin
// arbitration and a registered valid/ready output stage.
module cb_rr_nxm
    import cb_pkg::*;
#(
    parameter int WIDTH = CB_WIDTH,
    parameter int N_SRC = CB_N_SRC,
    parameter int N_DST = CB_N_DST,
    localparam int DW = cb_clog2(N_DST),
    localparam int SW = cb_clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       s_val,
    input  logic [N_SRC*DW-1:0]    s_dst,
    input  logic [N_SRC*WIDTH-1:0] s_data,
    output logic [N_SRC-1:0]       s_rdy,
    output logic [N_DST-1:0]       m_val,
    output logic [N_DST*SW-1:0]    m_src,
    output logic [N_DST*WIDTH-1:0] m_data,
    input  logic [N_DST-1:0]       m_rdy,
    output logic                   err_dst
);

    logic [N_SRC-1:0] req     [N_DST];
    logic [N_SRC-1:0] gnt     [N_DST];
    logic [SW-1:0]    gnt_idx [N_DST];
    logic             val_q   [N_DST];
    logic [SW-1:0]    src_q   [N_DST];
    logic [WIDTH-1:0] data_q  [N_DST];
    logic [N_DST-1:0] free;
    logic [N_DST-1:0] adv;
    logic [N_SRC-1:0] bad;

    // Request matrix; out-of-range destinations are swallowed as errors.
    always_comb begin
        bad = '0;
        for (int d = 0; d < N_DST; d++) begin
            req[d] = '0;
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (s_val[i] && int'(s_dst[i*DW +: DW]) >= N_DST) begin
                bad[i] = 1'b1;
            end
            for (int d = 0; d < N_DST; d++) begin
                if (s_val[i] && s_dst[i*DW +: DW] == DW'(d)) begin
                    req[d][i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        free = '0;
        adv  = '0;
        for (int d = 0; d < N_DST; d++) begin
            free[d] = !val_q[d] || m_rdy[d];
            adv[d]  = rst_n && free[d] && (|gnt[d]);
        end
    end

    always_comb begin
        s_rdy = bad;
        for (int d = 0; d < N_DST; d++) begin
            s_rdy = s_rdy | (gnt[d] & {N_SRC{free[d]}});
        end
        if (!rst_n) begin
            s_rdy = '0;
        end
    end

    for (genvar d = 0; d < N_DST; d++) begin : g_dst
        cb_rr_arb #(
            .N_SRC (N_SRC)
        ) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (req[d]),
            .advance (adv[d]),
            .gnt     (gnt[d]),
            .gnt_idx (gnt_idx[d])
        );

        // Refill takes priority over drain, so a free slot never bubbles.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                val_q[d]  <= 1'b0;
                src_q[d]  <= '0;
                data_q[d] <= '0;
            end else if (adv[d]) begin
                val_q[d]  <= 1'b1;
                src_q[d]  <= gnt_idx[d];
                data_q[d] <= s_data[int'(gnt_idx[d])*WIDTH +: WIDTH];
            end else if (m_rdy[d]) begin
                val_q[d]  <= 1'b0;
            end
        end

        assign m_val[d]                = val_q[d];
        assign m_src[d*SW +: SW]       = src_q[d];
        assign m_data[d*WIDTH +: WIDTH] = data_q[d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_dst <= 1'b0;
        end else begin
            err_dst <= |bad;
        end
    end

endmodule

// File: tb/tb_cb_rr_nxm.sv
// Directed bench for cb_rr_nxm: a 4x4 instance plus a 4x3 instance
// for out-of-range destination handling.
module tb_cb_rr_nxm;

    logic        clk;
    logic        rst_n;

    logic [3:0]  s_val;
    logic [7:0]  s_dst;
    logic [31:0] s_data;
    logic [3:0]  s_rdy;
    logic [3:0]  m_val;
    logic [7:0]  m_src;
    logic [31:0] m_data;
    logic [3:0]  m_rdy;
    logic        err_dst;

    logic [3:0]  t_val;
    logic [7:0]  t_dst;
    logic [31:0] t_data;
    logic [3:0]  t_rdy;
    logic [2:0]  t_mval;
    logic [5:0]  t_msrc;
    logic [23:0] t_mdata;
    logic [2:0]  t_mrdy;
    logic        t_err;

    int total;
    int bad;

    cb_rr_nxm #(
        .WIDTH (8),
        .N_SRC (4),
        .N_DST (4)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_val   (s_val),
        .s_dst   (s_dst),
        .s_data  (s_data),
        .s_rdy   (s_rdy),
        .m_val   (m_val),
        .m_src   (m_src),
        .m_data  (m_data),
        .m_rdy   (m_rdy),
        .err_dst (err_dst)
    );

    cb_rr_nxm #(
        .WIDTH (8),
        .N_SRC (4),
        .N_DST (3)
    ) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_val   (t_val),
        .s_dst   (t_dst),
        .s_data  (t_data),
        .s_rdy   (t_rdy),
        .m_val   (t_mval),
        .m_src   (t_msrc),
        .m_data  (t_mdata),
        .m_rdy   (t_mrdy),
        .err_dst (t_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic src(input int i, input logic v, input logic [1:0] d,
                       input logic [7:0] dat);
        s_val[i]         = v;
        s_dst[i*2 +: 2]  = d;
        s_data[i*8 +: 8] = dat;
    endtask

    // Source rule: a stalled beat must stay unchanged until accepted.
    logic [3:0]  pend;
    logic [7:0]  pend_dst;
    logic [31:0] pend_data;
    initial pend = '0;
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    total++;
                    assert (s_val[i] && s_dst[i*2 +: 2] == pend_dst[i*2 +: 2]
                            && s_data[i*8 +: 8] == pend_data[i*8 +: 8])
                    else begin
                        bad++;
                        $error("FAIL src_hold%0d observed=%0h expected=%0h",
                               i, s_data[i*8 +: 8], pend_data[i*8 +: 8]);
                    end
                end
            end
            pend = s_val & ~s_rdy;
        end else begin
            pend = '0;
        end
        pend_dst  = s_dst;
        pend_data = s_data;
    end

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        s_val  = '0;
        s_dst  = '0;
        s_data = '0;
        m_rdy  = 4'hF;
        t_val  = '0;
        t_dst  = '0;
        t_data = '0;
        t_mrdy = 3'b111;

        // Reset with every source pushing; nothing may move.
        src(0, 1'b1, 2'd0, 8'h2B);
        src(1, 1'b1, 2'd1, 8'h12);
        src(2, 1'b1, 2'd2, 8'h34);
        src(3, 1'b1, 2'd3, 8'h21);
        tick();
        tick();
        chk("rst_m_val", 64'(m_val), 64'h0);
        chk("rst_s_rdy", 64'(s_rdy), 64'h0);
        chk("rst_err", 64'(err_dst), 64'h0);
        chk("rst_m_data", 64'(m_data), 64'h0);
        chk("rst_m_src", 64'(m_src), 64'h0);
        chk("rst_err3", 64'(t_err), 64'h0);

        // Parallel: each source to its own destination.
        rst_n = 1'b1;
        #1;
        chk("par_s_rdy", 64'(s_rdy), 64'hF);
        tick();
        chk("par_m_val", 64'(m_val), 64'hF);
        chk("par_m_data", 64'(m_data), 64'h2134122B);
        chk("par_m_src", 64'(m_src), 64'hE4);
        s_val = '0;
        tick();
        chk("par_drain_val", 64'(m_val), 64'h0);
        chk("par_hold_data", 64'(m_data), 64'h2134122B);

        // Contention on destination 1 from a fresh pointer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src(i, 1'b1, 2'd1, 8'(8'h10 + i));
        end
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("cont_s_rdy", 64'(s_rdy), 64'(4'b0001 << (k % 4)));
            tick();
            chk("cont_m_src1", 64'(m_src[3:2]), 64'(k % 4));
            chk("cont_m_data1", 64'(m_data[15:8]), 64'(8'h10 + (k % 4)));
            chk("cont_m_val", 64'(m_val), 64'h2);
        end

        // Reset mid-stream: pointer sits at 2, must restart at source 0.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_rdy", 64'(s_rdy), 64'h0);
        tick();
        chk("mid_rst_m_val", 64'(m_val), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_s_rdy", 64'(s_rdy), 64'h1);
        tick();
        chk("mid_rel_m_src1", 64'(m_src[3:2]), 64'h0);
        chk("mid_rel_m_data1", 64'(m_data[15:8]), 64'h10);

        // Backpressure on destination 0.
        rst_n = 1'b0;
        s_val = '0;
        tick();
        rst_n = 1'b1;
        m_rdy = 4'b1110;
        src(0, 1'b1, 2'd0, 8'h22);
        #1;
        chk("bp_first_rdy", 64'(s_rdy), 64'h1);
        tick();
        chk("bp_first_val", 64'(m_val), 64'h1);
        chk("bp_first_data", 64'(m_data[7:0]), 64'h22);
        src(0, 1'b1, 2'd0, 8'h23);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_stall_rdy", 64'(s_rdy[0]), 64'h0);
            tick();
            chk("bp_stall_val", 64'(m_val[0]), 64'h1);
            chk("bp_stall_data", 64'(m_data[7:0]), 64'h22);
        end
        m_rdy = 4'hF;
        #1;
        chk("bp_drain_rdy", 64'(s_rdy[0]), 64'h1);
        tick();
        chk("bp_refill_val", 64'(m_val[0]), 64'h1);
        chk("bp_refill_data", 64'(m_data[7:0]), 64'h23);
        chk("bp_refill_src", 64'(m_src[1:0]), 64'h0);
        s_val = '0;
        tick();
        chk("bp_empty_val", 64'(m_val), 64'h0);
        chk("bp_empty_data", 64'(m_data[7:0]), 64'h23);

        // Out-of-range destination on the 3-destination instance.
        t_val  = 4'b0100;
        t_dst  = 8'b00_11_00_00;
        t_data = 32'h00550000;
        #1;
        chk("bad_s_rdy", 64'(t_rdy), 64'h4);
        chk("bad_err_pre", 64'(t_err), 64'h0);
        tick();
        t_val = '0;
        chk("bad_err_pulse", 64'(t_err), 64'h1);
        chk("bad_m_val", 64'(t_mval), 64'h0);
        tick();
        chk("bad_err_clear", 64'(t_err), 64'h0);
        chk("bad_m_val2", 64'(t_mval), 64'h0);

        // Two bad beats in one cycle plus a good one on destination 2.
        t_val  = 4'b1011;
        t_dst  = 8'b10_00_11_11;
        t_data = 32'h66000201;
        #1;
        chk("bad2_s_rdy", 64'(t_rdy), 64'hB);
        tick();
        t_val = '0;
        chk("bad2_err", 64'(t_err), 64'h1);
        chk("bad2_m_val", 64'(t_mval), 64'h4);
        chk("bad2_m_data2", 64'(t_mdata[23:16]), 64'h66);
        chk("bad2_m_src2", 64'(t_msrc[5:4]), 64'h3);
        tick();
        chk("bad2_err_clear", 64'(t_err), 64'h0);
        chk("main_err_quiet", 64'(err_dst), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
